// File: rtl/rename_regfile_mp_pkg.sv
// rename_regfile_mp_pkg: shared default geometry for the rename register file.
package rename_regfile_mp_pkg;
  localparam int READ_PORTS_D     = 4;
  localparam int RENAME_PORTS_D   = 2;
  localparam int COMMIT_PORTS_D   = 2;
  localparam int REG_ADDR_WIDTH_D = 5;
  localparam int DATA_WIDTH_D     = 32;
  localparam int ROB_ADDR_WIDTH_D = 4;
endpackage

// File: rtl/rename_regfile_entry.sv
// rename_regfile_entry: one architectural register holding a committed value and an optional ROB tag.
module rename_regfile_entry
  import rename_regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      restore,
  input  logic                      ren_hit,
  input  logic [ROB_ADDR_WIDTH-1:0] ren_tag,
  input  logic                      com_hit,
  input  logic [ROB_ADDR_WIDTH-1:0] com_tag,
  input  logic [DATA_WIDTH-1:0]     com_data,
  output logic [DATA_WIDTH-1:0]     value,
  output logic                      valid,
  output logic [ROB_ADDR_WIDTH-1:0] tag
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      valid <= 1'b0;
      tag   <= '0;
    end else begin
      if (com_hit) value <= com_data;
      if (ren_hit && !restore) tag <= ren_tag;
      valid <= restore ? 1'b0 : ren_hit ? 1'b1 : (com_hit && tag == com_tag) ? 1'b0 : valid;
    end
  end
endmodule

// File: rtl/rename_regfile_mp.sv
// rename_regfile_mp: multi-ported architectural register file with rename tags and commit bypass.
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
#(
  parameter int READ_PORTS     = READ_PORTS_D,
  parameter int RENAME_PORTS   = RENAME_PORTS_D,
  parameter int COMMIT_PORTS   = COMMIT_PORTS_D,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_D,
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_D
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [RENAME_PORTS-1:0]               write_en,
  input  logic [RENAME_PORTS*REG_ADDR_WIDTH-1:0] write_addr,
  input  logic [RENAME_PORTS*ROB_ADDR_WIDTH-1:0] write_ref_id,
  input  logic [COMMIT_PORTS-1:0]               commit_en,
  input  logic                                  commit_restore,
  input  logic [COMMIT_PORTS*REG_ADDR_WIDTH-1:0] commit_addr,
  input  logic [COMMIT_PORTS*ROB_ADDR_WIDTH-1:0] commit_ref_id,
  input  logic [COMMIT_PORTS*DATA_WIDTH-1:0]    commit_data,
  input  logic [READ_PORTS-1:0]                 read_en,
  input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0]  read_addr,
  output logic [READ_PORTS-1:0]                 read_is_ref,
  output logic [READ_PORTS*DATA_WIDTH-1:0]      read_data
);
  localparam int REG_COUNT = 1 << REG_ADDR_WIDTH;
  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int RW = ROB_ADDR_WIDTH;
  logic [REG_COUNT-1:0][DW-1:0] value, byp_data;
  logic [REG_COUNT-1:0][RW-1:0] tag;
  logic [REG_COUNT-1:0]         valid, byp;
  logic [AW-1:0]                a;
  assign value[0]    = '0;
  assign tag[0]      = '0;
  assign valid[0]    = 1'b0;
  assign byp[0]      = 1'b0;
  assign byp_data[0] = '0;
  for (genvar r = 1; r < REG_COUNT; r++) begin : g_reg
    logic          rh, ch;
    logic [RW-1:0] rt, ct;
    logic [DW-1:0] cd;
    // Ascending port scan so the highest matching port index wins.
    always_comb begin
      rh = 1'b0;
      rt = '0;
      ch = 1'b0;
      ct = '0;
      cd = '0;
      for (int p = 0; p < RENAME_PORTS; p++)
        if (write_en[p] && write_addr[p*AW +: AW] == AW'(r)) begin
          rh = 1'b1;
          rt = write_ref_id[p*RW +: RW];
        end
      for (int p = 0; p < COMMIT_PORTS; p++)
        if (commit_en[p] && commit_addr[p*AW +: AW] == AW'(r)) begin
          ch = 1'b1;
          ct = commit_ref_id[p*RW +: RW];
          cd = commit_data[p*DW +: DW];
        end
    end
    assign byp[r]      = ch && valid[r] && tag[r] == ct;
    assign byp_data[r] = cd;
    rename_regfile_entry #(.DATA_WIDTH(DW), .ROB_ADDR_WIDTH(RW)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .restore  (commit_restore),
      .ren_hit  (rh),
      .ren_tag  (rt),
      .com_hit  (ch),
      .com_tag  (ct),
      .com_data (cd),
      .value    (value[r]),
      .valid    (valid[r]),
      .tag      (tag[r])
    );
  end
  always_comb begin
    read_is_ref = '0;
    read_data   = '0;
    a           = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      a = read_addr[i*AW +: AW];
      if (rst && read_en[i]) begin
        read_is_ref[i]       = valid[a] && !byp[a];
        read_data[i*DW +: DW] = byp[a] ? byp_data[a] : valid[a] ? DW'(tag[a]) : value[a];
      end
    end
  end
endmodule

// File: tb/tb_rename_regfile_mp.sv
// tb_rename_regfile_mp: directed and randomized checks of rename_regfile_mp against an array model.
module tb_rename_regfile_mp;
  logic         clk, rst;
  logic [1:0]   write_en;
  logic [9:0]   write_addr;
  logic [7:0]   write_ref_id;
  logic [1:0]   commit_en;
  logic         commit_restore;
  logic [9:0]   commit_addr;
  logic [7:0]   commit_ref_id;
  logic [63:0]  commit_data;
  logic [3:0]   read_en;
  logic [19:0]  read_addr;
  logic [3:0]   read_is_ref;
  logic [127:0] read_data;
  int checks = 0, errors = 0;
  logic [31:0] mval[32];
  logic        mvalid[32];
  logic [3:0]  mtag[32];

  rename_regfile_mp dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .write_ref_id(write_ref_id),
    .commit_en(commit_en), .commit_restore(commit_restore), .commit_addr(commit_addr),
    .commit_ref_id(commit_ref_id), .commit_data(commit_data),
    .read_en(read_en), .read_addr(read_addr),
    .read_is_ref(read_is_ref), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    write_en = '0; write_addr = '0; write_ref_id = '0;
    commit_en = '0; commit_restore = 1'b0; commit_addr = '0; commit_ref_id = '0; commit_data = '0;
    read_en = '0; read_addr = '0;
  endtask

  task automatic set_ren(input int p, input logic [4:0] a, input logic [3:0] t);
    write_en[p] = 1'b1; write_addr[p*5 +: 5] = a; write_ref_id[p*4 +: 4] = t;
  endtask

  task automatic set_com(input int p, input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
    commit_en[p] = 1'b1; commit_addr[p*5 +: 5] = a; commit_ref_id[p*4 +: 4] = t; commit_data[p*32 +: 32] = d;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    read_en[p] = 1'b1; read_addr[p*5 +: 5] = a;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin mval[r] = '0; mvalid[r] = 1'b0; mtag[r] = '0; end
  endtask

  // Apply one clock of architectural effects in the order: commits, tag release, then restore or renames.
  task automatic model_update();
    bit         hc[32];
    logic [3:0] ct[32];
    for (int r = 0; r < 32; r++) begin hc[r] = 0; ct[r] = '0; end
    for (int p = 0; p < 2; p++) begin
      int a = int'(commit_addr[p*5 +: 5]);
      if (commit_en[p] && a != 0) begin mval[a] = commit_data[p*32 +: 32]; hc[a] = 1; ct[a] = commit_ref_id[p*4 +: 4]; end
    end
    for (int r = 1; r < 32; r++) if (hc[r] && mvalid[r] && mtag[r] == ct[r]) mvalid[r] = 1'b0;
    if (commit_restore) for (int r = 0; r < 32; r++) mvalid[r] = 1'b0;
    else for (int p = 0; p < 2; p++) begin
      int a = int'(write_addr[p*5 +: 5]);
      if (write_en[p] && a != 0) begin mvalid[a] = 1'b1; mtag[a] = write_ref_id[p*4 +: 4]; end
    end
  endtask

  function automatic void exp_read(input int p, output logic isr, output logic [31:0] d);
    int a = int'(read_addr[p*5 +: 5]);
    bit hit = 0;
    logic [3:0]  t = '0;
    logic [31:0] cd = '0;
    for (int c = 0; c < 2; c++)
      if (commit_en[c] && int'(commit_addr[c*5 +: 5]) == a) begin hit = 1; t = commit_ref_id[c*4 +: 4]; cd = commit_data[c*32 +: 32]; end
    isr = 1'b0; d = '0;
    if (!rst || !read_en[p] || a == 0) return;
    if (hit && mvalid[a] && mtag[a] == t) d = cd;
    else begin isr = mvalid[a]; d = mvalid[a] ? {28'd0, mtag[a]} : mval[a]; end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear_in(); model_reset();
    for (int p = 0; p < 4; p++) set_rd(p, 5'(p + 1));
    #2;
    checks++;
    if (read_is_ref !== 4'b0 || read_data !== 128'b0) begin errors++;
      $display("FAIL reset_low: got ref=%b data=%h, expected all 0", read_is_ref, read_data); end
    #10 rst = 1'b1;
    #1;
    checks++;
    if (read_is_ref !== 4'b0 || read_data !== 128'b0) begin errors++;
      $display("FAIL reset_state: got ref=%b data=%h, expected all 0", read_is_ref, read_data); end
    tick();
  endtask

  task automatic test_commit();
    clear_in(); set_com(0, 5'd1, 4'h0, 32'h12345678);
    tick();
    clear_in(); set_rd(0, 5'd1); #1;
    checks++;
    if (read_is_ref[0] !== 1'b0 || read_data[31:0] !== 32'h12345678) begin errors++;
      $display("FAIL commit_read: got ref=%b data=%h, expected ref=0 data=12345678", read_is_ref[0], read_data[31:0]); end
    tick();
  endtask

  task automatic test_rename_dup();
    clear_in(); set_ren(0, 5'd3, 4'h5); set_ren(1, 5'd3, 4'h6); set_rd(1, 5'd3); #1;
    checks++;
    if (read_is_ref[1] !== 1'b0 || read_data[63:32] !== 32'h0) begin errors++;
      $display("FAIL rename_not_visible: got ref=%b data=%h, expected ref=0 data=0", read_is_ref[1], read_data[63:32]); end
    tick();
    clear_in(); set_rd(2, 5'd3); #1;
    checks++;
    if (read_is_ref[2] !== 1'b1 || read_data[95:64] !== 32'h6) begin errors++;
      $display("FAIL rename_dup_port: got ref=%b data=%h, expected ref=1 data=6", read_is_ref[2], read_data[95:64]); end
    tick();
  endtask

  task automatic test_rename_commit_same();
    clear_in(); set_ren(1, 5'd2, 4'hF); set_com(0, 5'd2, 4'hF, 32'hABCDEF00);
    tick();
    clear_in(); set_rd(3, 5'd2); #1;
    checks++;
    if (read_is_ref[3] !== 1'b1 || read_data[127:96] !== 32'hF) begin errors++;
      $display("FAIL rename_beats_commit: got ref=%b data=%h, expected ref=1 data=f", read_is_ref[3], read_data[127:96]); end
    tick();
  endtask

  task automatic test_bypass();
    clear_in(); set_ren(0, 5'd1, 4'hA); tick();
    clear_in(); set_com(1, 5'd1, 4'hA, 32'h77); set_rd(0, 5'd1); #1;
    checks++;
    if (read_is_ref[0] !== 1'b0 || read_data[31:0] !== 32'h77) begin errors++;
      $display("FAIL bypass_match: got ref=%b data=%h, expected ref=0 data=77", read_is_ref[0], read_data[31:0]); end
    tick();
    clear_in(); set_rd(0, 5'd1); #1;
    checks++;
    if (read_is_ref[0] !== 1'b0 || read_data[31:0] !== 32'h77) begin errors++;
      $display("FAIL commit_clears_tag: got ref=%b data=%h, expected ref=0 data=77", read_is_ref[0], read_data[31:0]); end
    clear_in(); set_ren(1, 5'd1, 4'hA); tick();
    clear_in(); set_com(0, 5'd1, 4'hB, 32'h88); set_rd(1, 5'd1); #1;
    checks++;
    if (read_is_ref[1] !== 1'b1 || read_data[63:32] !== 32'hA) begin errors++;
      $display("FAIL bypass_mismatch: got ref=%b data=%h, expected ref=1 data=a", read_is_ref[1], read_data[63:32]); end
    tick();
    clear_in(); set_rd(1, 5'd1); #1;
    checks++;
    if (read_is_ref[1] !== 1'b1 || read_data[63:32] !== 32'hA) begin errors++;
      $display("FAIL mismatch_keeps_tag: got ref=%b data=%h, expected ref=1 data=a", read_is_ref[1], read_data[63:32]); end
  endtask

  task automatic test_restore();
    logic [31:0] want[6];
    want[1] = 32'h88; want[2] = 32'hABCDEF00; want[3] = 32'h33; want[4] = 32'h44; want[5] = 32'h0;
    clear_in(); set_com(0, 5'd3, 4'h0, 32'h33); set_com(1, 5'd4, 4'h0, 32'h44); tick();
    clear_in(); set_ren(0, 5'd3, 4'h1); set_ren(1, 5'd4, 4'h2); tick();
    clear_in(); set_ren(0, 5'd2, 4'h3); tick();
    clear_in(); commit_restore = 1'b1; set_ren(0, 5'd5, 4'h7); tick();
    for (int g = 0; g < 2; g++) begin
      clear_in();
      for (int p = 0; p < 4; p++) if (g * 4 + p + 1 <= 5) set_rd(p, 5'(g * 4 + p + 1));
      #1;
      for (int p = 0; p < 4; p++) if (g * 4 + p + 1 <= 5) begin
        checks++;
        if (read_is_ref[p] !== 1'b0 || read_data[p*32 +: 32] !== want[g*4+p+1]) begin errors++;
          $display("FAIL restore reg%0d: got ref=%b data=%h, expected ref=0 data=%h",
                   g*4+p+1, read_is_ref[p], read_data[p*32 +: 32], want[g*4+p+1]); end
      end
    end
    tick();
  endtask

  task automatic test_reg0();
    clear_in(); set_ren(0, 5'd0, 4'h3); set_com(1, 5'd0, 4'h3, 32'hFF); set_rd(0, 5'd0); #1;
    checks++;
    if (read_is_ref[0] !== 1'b0 || read_data[31:0] !== 32'h0) begin errors++;
      $display("FAIL reg0_same_cycle: got ref=%b data=%h, expected ref=0 data=0", read_is_ref[0], read_data[31:0]); end
    tick();
    clear_in(); set_rd(3, 5'd0); #1;
    checks++;
    if (read_is_ref[3] !== 1'b0 || read_data[127:96] !== 32'h0) begin errors++;
      $display("FAIL reg0_after: got ref=%b data=%h, expected ref=0 data=0", read_is_ref[3], read_data[127:96]); end
  endtask

  task automatic test_random(input int n);
    logic ei; logic [31:0] ed;
    for (int cyc = 0; cyc < n; cyc++) begin
      clear_in();
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1) set_ren(p, 5'($urandom_range(0, 7)), 4'($urandom));
        if ($urandom_range(0, 1) == 1) set_com(p, 5'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), $urandom);
      end
      commit_restore = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < 4; p++) if ($urandom_range(0, 3) != 0) set_rd(p, 5'($urandom_range(0, 7)));
      #1;
      for (int p = 0; p < 4; p++) begin
        exp_read(p, ei, ed);
        checks++;
        if (read_is_ref[p] !== ei || read_data[p*32 +: 32] !== ed) begin errors++;
          $display("FAIL rand_read cyc=%0d port=%0d addr=%0d: got ref=%b data=%h, expected ref=%b data=%h",
                   cyc, p, read_addr[p*5 +: 5], read_is_ref[p], read_data[p*32 +: 32], ei, ed); end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    clear_in(); set_ren(0, 5'd6, 4'h9); set_com(0, 5'd7, 4'h0, 32'hCAFE);
    for (int p = 0; p < 4; p++) set_rd(p, 5'(p + 4));
    #2 rst = 1'b0;
    #1;
    checks++;
    if (read_is_ref !== 4'b0 || read_data !== 128'b0) begin errors++;
      $display("FAIL async_reset_outputs: got ref=%b data=%h, expected all 0", read_is_ref, read_data); end
    @(posedge clk); #1;
    model_reset();
    clear_in(); rst = 1'b1;
    for (int p = 0; p < 4; p++) set_rd(p, 5'(p + 4));
    #1;
    checks++;
    if (read_is_ref !== 4'b0 || read_data !== 128'b0) begin errors++;
      $display("FAIL async_reset_state: got ref=%b data=%h, expected all 0", read_is_ref, read_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_commit();
    test_rename_dup();
    test_rename_commit_same();
    test_bypass();
    test_restore();
    test_reg0();
    model_reset();
    for (int r = 1; r < 6; r++) mval[r] = (r == 1) ? 32'h88 : (r == 2) ? 32'hABCDEF00 : (r == 3) ? 32'h33 : (r == 4) ? 32'h44 : 32'h0;
    test_random(400);
    test_async_reset();
    test_random(100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
